key_event_fsm: RTL
==================

Name: key_event_fsm

Overview:
- Downstream consumer of the debounced key level produced by the key debouncer in the CLOCK design.
- Classifies each press as a short press, a long press, or a held key with auto-repeat.
- Emits single-cycle event pulses in the 50 MHz clk domain for the time-setting logic.
- The debounced input is re-synchronised to clk, because the debouncer runs on a derived 5 kHz clock.

Parameters:
- TICK_DIV, 50000: clk cycles per time tick (50000 = 1 ms at 50 MHz); must be >= 2.
- LONG_TICKS, 1000: ticks of continuous press before a long press is declared; range 1..65535.
- REPEAT_TICKS, 200: ticks between auto-repeat pulses while held after a long press; range 1..65535.
- KEY_ACTIVE_LOW, 1: 1 = key_db low means pressed; 0 = key_db high means pressed.

Ports:
- clk  input  1  system clock, 50 MHz.
- nRST  input  1  asynchronous active-low reset.
- key_db  input  1  debounced key level from the debouncer.
- key_pressed  output  1  synchronised, polarity-corrected press level (1 = pressed).
- short_pulse  output  1  one-cycle pulse: released before LONG_TICKS elapsed.
- long_pulse  output  1  one-cycle pulse: press reached LONG_TICKS.
- repeat_pulse  output  1  one-cycle auto-repeat pulse (see Optional Feature).
- state_o  output  2  current FSM state, for debug.

Behaviour:
- Interface: one clock, clk; reset nRST is asynchronous, active-low. All flops clear on nRST low.
- Reset values:
  - key_pressed, short_pulse, long_pulse, repeat_pulse all 0.
  - state_o = IDLE (2'd0).
  - Sync flops are loaded with the not-pressed level.
  - Prescaler and tick counter are 0.
- Synchroniser: 2-flop chain on key_db, then polarity inversion if KEY_ACTIVE_LOW. The result is p; key_pressed = p. A key_db change appears on key_pressed 2 clk cycles later.
- Timebase:
  - Prescaler runs 0..TICK_DIV-1; tick is high for one cycle when prescaler == TICK_DIV-1.
  - Tick counter tcnt is 16 bits and counts ticks.
  - Prescaler and tcnt are both cleared on every state entry and on every repeat_pulse.
  - They hold at 0 in IDLE.
- States: IDLE=0, PRESS=1, HOLD=2, value 3 unused. Any illegal state returns to IDLE on the next clk with no pulse.
- IDLE:
  - p=1 → PRESS.
- PRESS:
  - p=0 → IDLE, short_pulse=1 for one cycle.
  - Else, on a tick where tcnt == LONG_TICKS-1 → HOLD, long_pulse=1 for one cycle.
  - If release and the long threshold occur in the same cycle, release wins: short_pulse only.
- HOLD:
  - p=0 → IDLE, no pulse.
  - Else, on a tick where tcnt == REPEAT_TICKS-1 → repeat_pulse=1 (feature enabled); stay in HOLD.
  - Release beats a repeat in the same cycle.
- Latency and pulse rules:
  - All pulses are registered and asserted in the cycle the FSM leaves or acts, i.e. the same edge that updates state_o.
  - short_pulse rises 3 clk cycles after the key_db release transition.
  - long_pulse rises LONG_TICKS*TICK_DIV cycles after state_o becomes PRESS.
  - At most one of the three pulses is high in any cycle.
  - Exactly one short_pulse or long_pulse is produced per press.
- Mid-operation reset: nRST low in any state immediately forces IDLE with all pulses 0. After reset release, a key still held is treated as a new press (IDLE→PRESS).

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: HOLD generates repeat_pulse every REPEAT_TICKS ticks as described.
- Undefined:
  - repeat_pulse is tied to 0 and the REPEAT_TICKS compare logic is not built.
  - HOLD only waits for release; tcnt is held at 0 in HOLD.

Test Plan (TICK_DIV=10, LONG_TICKS=5, REPEAT_TICKS=2, KEY_ACTIVE_LOW=1, KEY_REPEAT_EN defined):
- Reset: nRST=0 with key_db=0 → all pulses 0, state_o=0, key_pressed=0. Release nRST with key_db=0 → state_o=1 three cycles later.
- Short press: key_db low for 20 cycles then high → exactly one short_pulse, 3 cycles after the rising key_db. No long_pulse. state_o returns to 0.
- Long press: key_db low for 49 cycles after PRESS entry → long_pulse exactly 50 cycles after entry. On release: no short_pulse, state_o 2→0.
- Auto-repeat: hold 50+45 cycles after PRESS entry → repeat_pulse at +20 and +40 after long_pulse, never together with long_pulse. Release → no further pulses.
- Boundary: release timed so p falls in the long-threshold cycle → short_pulse=1, long_pulse=0.
- Reset mid-HOLD: nRST low for 3 cycles while held → pulses 0, state_o=0. After release, a fresh PRESS with long_pulse 50 cycles after re-entry. With KEY_REPEAT_EN undefined, the same auto-repeat stimulus gives repeat_pulse constantly 0.

Source files
------------

// File: rtl/key_event_fsm.sv
// key_event_fsm: classifies debounced key presses into short/long/auto-repeat pulses.
// Auto-repeat in HOLD is built only when KEY_REPEAT_EN is defined.
module key_event_fsm #(
  parameter int TICK_DIV       = 50000,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       key_db,
  output logic       key_pressed,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic [1:0] state_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [1:0] IDLE = 2'd0, PRESS = 2'd1, HOLD = 2'd2;
  localparam logic IDLE_LVL = KEY_ACTIVE_LOW;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic s1_q, s2_q, p, tick, run;
  logic short_q, short_d, long_q, long_d, rep_q, rep_d;
  assign p = KEY_ACTIVE_LOW ? ~s2_q : s2_q;
  assign tick = pre_q == PW'(TICK_DIV - 1);
  assign key_pressed = p;
  assign short_pulse = short_q;
  assign long_pulse = long_q;
  assign repeat_pulse = rep_q;
  assign state_o = state_q;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      s1_q    <= IDLE_LVL;
      s2_q    <= IDLE_LVL;
      state_q <= IDLE;
      pre_q   <= '0;
      tcnt_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      s1_q    <= key_db;
      s2_q    <= s1_q;
      state_q <= state_d;
      pre_q   <= pre_d;
      tcnt_q  <= tcnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end
  // Timebase restarts whenever the state changes or a repeat fires.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = p ? PRESS : IDLE;
      PRESS:   state_d = !p ? IDLE : (tick && tcnt_q == 16'(LONG_TICKS - 1)) ? HOLD : PRESS;
      HOLD:    state_d = p ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
`ifdef KEY_REPEAT_EN
    run = state_d == state_q && state_q != IDLE && !rep_d;
`else
    run = state_d == state_q && state_q == PRESS;
`endif
    pre_d  = (!run || tick) ? '0 : pre_q + 1'b1;
    tcnt_d = !run ? '0 : tcnt_q + 16'(tick);
  end
  always_comb begin
    short_d = state_q == PRESS && !p;
    long_d  = state_q == PRESS && p && tick && tcnt_q == 16'(LONG_TICKS - 1);
`ifdef KEY_REPEAT_EN
    rep_d   = state_q == HOLD && p && tick && tcnt_q == 16'(REPEAT_TICKS - 1);
`else
    rep_d   = 1'b0;
`endif
  end
endmodule
